// File: rtl/somador_pkg.sv
// somador_pkg: shared state encoding and default sizing for the streaming multi-operand adder.
package somador_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACUMULA   = 2'd1,
        RESULTADO = 2'd2
    } state_t;
    localparam int DATA_W_DEF     = 4;
    localparam int N_OPERANDS_DEF = 6;
endpackage

// File: rtl/acumulador_somador.sv
// acumulador_somador: running-sum register with synchronous clear and add-enable.
module acumulador_somador #(
    parameter int DATA_W = 4,
    parameter int SUM_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [SUM_W-1:0]  acc
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (add) acc <= acc + SUM_W'(din);
endmodule

// File: rtl/controlador_somador.sv
// controlador_somador: streams N_OPERANDS operands through a handshake, sums them and
// holds the sum and its odd flag until the consumer takes it.
module controlador_somador
    import somador_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int N_OPERANDS = N_OPERANDS_DEF,
    localparam int CNT_W     = $clog2(N_OPERANDS),
    localparam int SUM_W     = DATA_W + $clog2(N_OPERANDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  soma,
    output logic              impar,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);
    state_t           state, state_next;
    logic [SUM_W-1:0] acc, sum_next;
    logic             accept, last, restart;

    assign accept    = in_valid && (state == ACUMULA);
    assign last      = accept && (count == CNT_W'(N_OPERANDS - 1));
    assign restart   = start && ((state == IDLE) || (state == RESULTADO && res_ready));
    assign sum_next  = acc + SUM_W'(in_data);
    assign in_ready  = (state == ACUMULA);
    assign res_valid = (state == RESULTADO);
    assign busy      = (state != IDLE);
    assign impar     = soma[0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = ACUMULA;
            ACUMULA:   if (last) state_next = RESULTADO;
            RESULTADO: if (res_ready) state_next = start ? ACUMULA : IDLE;
            default:   state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    // count returns to 0 on the final accept so the result phase always reports 0
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                        count <= '0;
        else if (clear || restart || last) count <= '0;
        else if (accept)                   count <= count + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)     soma <= '0;
        else if (clear) soma <= '0;
        else if (last)  soma <= sum_next;

    acumulador_somador #(.DATA_W(DATA_W), .SUM_W(SUM_W)) u_acc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear || restart),
        .add  (accept),
        .din  (in_data),
        .acc  (acc)
    );
endmodule

// File: tb/tb_controlador_somador.sv
// tb_controlador_somador: directed and randomized checks of controlador_somador against a
// queue-based model of the accepted operands.
module tb_controlador_somador;
    logic       clk = 0, rst_n = 0, start = 0, clear = 0, in_valid = 0, res_ready = 0;
    logic [3:0] in_data = 0;
    logic       in_ready, res_valid, impar, busy;
    logic [6:0] soma;
    logic [2:0] count;
    int compared = 0, mismatched = 0;
    int q[$];

    controlador_somador dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .res_valid(res_valid), .res_ready(res_ready),
        .soma(soma), .impar(impar), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic begin_sum;
        start = 1;
        tick;
        start = 0;
        q.delete();
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
        check("start_count", count, 0);
    endtask

    task automatic stream(input int v[6], input bit bub);
        for (int i = 0; i < 6; i++) begin
            if (bub) begin
                int nb = $urandom_range(1, 3);
                in_valid = 0;
                in_data = 4'($urandom);
                repeat (nb) tick;
                check("bubble_count", count, q.size());
                check("bubble_ready", in_ready, 1);
            end
            check("pre_count", count, q.size());
            check("pre_res_valid", res_valid, 0);
            in_valid = 1;
            in_data = 4'(v[i]);
            tick;
            q.push_back(v[i]);
            in_valid = 0;
        end
        check("res_valid", res_valid, 1);
        check("soma", soma, model_sum());
        check("impar", impar, model_sum() % 2);
        check("res_count", count, 0);
        check("res_in_ready", in_ready, 0);
    endtask

    task automatic consume;
        res_ready = 1;
        tick;
        res_ready = 0;
        check("consume_busy", busy, 0);
        check("consume_res_valid", res_valid, 0);
    endtask

    initial begin
        int v[6];
        logic [6:0] held;
        #12;
        check("rst_busy", busy, 0);
        check("rst_soma", soma, 0);
        check("rst_count", count, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1;
        tick;
        check("idle_busy", busy, 0);

        begin_sum;
        v = '{1, 2, 4, 0, 9, 1};
        stream(v, 0);
        check("t1_17", soma, 17);
        consume;

        begin_sum;
        v = '{3, 4, 10, 3, 6, 6};
        stream(v, 1);
        check("t2_32", soma, 32);
        consume;

        begin_sum;
        v = '{15, 15, 15, 15, 15, 15};
        stream(v, 0);
        check("t3_90", soma, 90);
        check("t3_impar", impar, 0);

        held = soma;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1;
            in_data = 4'($urandom);
            start = 1'($urandom);
            tick;
            check("hold_res_valid", res_valid, 1);
            check("hold_soma", soma, held);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 0;
        res_ready = 1;
        start = 1;
        tick;
        res_ready = 0;
        start = 0;
        q.delete();
        check("t4_acumula", in_ready, 1);
        check("t4_res_valid", res_valid, 0);
        check("t4_count", count, 0);
        for (int i = 0; i < 6; i++) v[i] = $urandom_range(0, 15);
        stream(v, 1);
        consume;

        begin_sum;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_data = 4'($urandom_range(1, 15));
            tick;
        end
        in_valid = 1;
        clear = 1;
        start = 1;
        tick;
        clear = 0;
        start = 0;
        in_valid = 0;
        check("clr_busy", busy, 0);
        check("clr_count", count, 0);
        check("clr_soma", soma, 0);
        check("clr_impar", impar, 0);
        begin_sum;
        v = '{1, 2, 3, 4, 5, 6};
        stream(v, 0);
        check("t5_21", soma, 21);
        check("t5_impar", impar, 1);
        consume;

        begin_sum;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data = 4'($urandom_range(0, 15));
            tick;
        end
        in_valid = 0;
        check("t6_count4", count, 4);
        #2;
        rst_n = 0;
        start = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        check("arst_soma", soma, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_res_valid", res_valid, 0);
        tick;
        tick;
        check("arst_start_ignored", busy, 0);
        start = 0;
        #2;
        rst_n = 1;
        tick;
        check("post_rst_idle", busy, 0);

        for (int r = 0; r < 4; r++) begin
            begin_sum;
            for (int i = 0; i < 6; i++) v[i] = $urandom_range(0, 15);
            stream(v, 1'($urandom));
            consume;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
